// File: rtl/vx_mem_responder_if.sv
// ============================================================================
// Module   : vx_mem_responder_if
// Brief    : mem_req / mem_rsp valid-ready bundle between a memory master and
//            the memory-side responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vx_mem_responder_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 8
);
    logic                      mem_req_valid;
    logic                      mem_req_rw;
    logic [DATA_WIDTH/8-1:0]   mem_req_byteen;
    logic [ADDR_WIDTH-1:0]     mem_req_addr;
    logic [DATA_WIDTH-1:0]     mem_req_data;
    logic [TAG_WIDTH-1:0]      mem_req_tag;
    logic                      mem_req_ready;

    logic                      mem_rsp_valid;
    logic [DATA_WIDTH-1:0]     mem_rsp_data;
    logic [TAG_WIDTH-1:0]      mem_rsp_tag;
    logic                      mem_rsp_ready;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
               mem_req_data, mem_req_tag, mem_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
               mem_req_data, mem_req_tag, mem_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
    );
endinterface

`default_nettype wire

// File: rtl/vx_mem_responder.sv
// ============================================================================
// Module   : vx_mem_responder
// Brief    : Byte-enabled word RAM answering reads in order after a fixed
//            latency, with credit-limited outstanding reads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vx_mem_responder #(
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 26,
    parameter int TAG_WIDTH      = 8,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int LATENCY        = 4,
    parameter int RSP_QUEUE_SIZE = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    vx_mem_responder_if.slave  mem_if,
    output logic               busy
);
    localparam int c_NUM_BYTES  = DATA_WIDTH / 8;
    localparam int c_MEM_DEPTH  = 1 << MEM_DEPTH_LOG2;
    localparam int c_QPTR_W     = $clog2(RSP_QUEUE_SIZE);
    localparam int c_CNT_W      = c_QPTR_W + 1;
    // The response queue itself supplies the last cycle of latency.
    localparam int c_PIPE_DEPTH = LATENCY - 1;
    localparam logic [c_CNT_W-1:0] c_CREDITS = c_CNT_W'(RSP_QUEUE_SIZE);

    logic [DATA_WIDTH-1:0]     r_mem [c_MEM_DEPTH];
    logic [c_CNT_W-1:0]        r_outstanding;
    logic [MEM_DEPTH_LOG2-1:0] w_idx;
    logic                      w_req_fire;
    logic                      w_wr_fire;
    logic                      w_rd_fire;
    logic                      w_rsp_fire;
    logic                      w_pipe_out_valid;
    logic [DATA_WIDTH-1:0]     w_pipe_out_data;
    logic [TAG_WIDTH-1:0]      w_pipe_out_tag;

    logic [DATA_WIDTH-1:0]     r_q_data [RSP_QUEUE_SIZE];
    logic [TAG_WIDTH-1:0]      r_q_tag  [RSP_QUEUE_SIZE];
    logic [c_CNT_W-1:0]        r_wr_ptr;
    logic [c_CNT_W-1:0]        r_rd_ptr;
    logic                      w_q_empty;
    logic                      w_q_full;

    assign w_idx      = mem_if.mem_req_addr[MEM_DEPTH_LOG2-1:0];
    assign w_req_fire = mem_if.mem_req_valid && mem_if.mem_req_ready;
    assign w_wr_fire  = w_req_fire && mem_if.mem_req_rw;
    assign w_rd_fire  = w_req_fire && !mem_if.mem_req_rw;
    assign w_rsp_fire = !w_q_empty && mem_if.mem_rsp_ready;

    // Credit check covers both pipe and queue, so the queue can never overflow.
    assign mem_if.mem_req_ready = (r_outstanding < c_CREDITS);
    assign busy                 = (r_outstanding != '0);

    generate
        if (MEM_DEPTH_LOG2 < ADDR_WIDTH) begin : g_addr_alias
            logic w_addr_hi_unused;
            assign w_addr_hi_unused = ^mem_if.mem_req_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_rd_fire, w_rsp_fire})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int b = 0; b < c_NUM_BYTES; b++) begin
                if (mem_if.mem_req_byteen[b]) begin
                    r_mem[w_idx][8*b +: 8] <= mem_if.mem_req_data[8*b +: 8];
                end
            end
        end
    end

    generate
        if (c_PIPE_DEPTH > 0) begin : g_pipe
            logic [c_PIPE_DEPTH-1:0] r_valid;
            logic [DATA_WIDTH-1:0]   r_data [c_PIPE_DEPTH];
            logic [TAG_WIDTH-1:0]    r_tag  [c_PIPE_DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_valid <= '0;
                end else begin
                    r_valid[0] <= w_rd_fire;
                    for (int i = 1; i < c_PIPE_DEPTH; i++) begin
                        r_valid[i] <= r_valid[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (w_rd_fire) begin
                    r_data[0] <= r_mem[w_idx];
                    r_tag[0]  <= mem_if.mem_req_tag;
                end
                for (int i = 1; i < c_PIPE_DEPTH; i++) begin
                    r_data[i] <= r_data[i-1];
                    r_tag[i]  <= r_tag[i-1];
                end
            end

            assign w_pipe_out_valid = r_valid[c_PIPE_DEPTH-1];
            assign w_pipe_out_data  = r_data[c_PIPE_DEPTH-1];
            assign w_pipe_out_tag   = r_tag[c_PIPE_DEPTH-1];
        end else begin : g_no_pipe
            assign w_pipe_out_valid = w_rd_fire;
            assign w_pipe_out_data  = r_mem[w_idx];
            assign w_pipe_out_tag   = mem_if.mem_req_tag;
        end
    endgenerate

    assign w_q_empty = (r_wr_ptr == r_rd_ptr);
    assign w_q_full  = (r_wr_ptr[c_QPTR_W] != r_rd_ptr[c_QPTR_W])
                    && (r_wr_ptr[c_QPTR_W-1:0] == r_rd_ptr[c_QPTR_W-1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_pipe_out_valid) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rsp_fire)       r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pipe_out_valid) begin
            r_q_data[r_wr_ptr[c_QPTR_W-1:0]] <= w_pipe_out_data;
            r_q_tag[r_wr_ptr[c_QPTR_W-1:0]]  <= w_pipe_out_tag;
        end
    end

    assign mem_if.mem_rsp_valid = !w_q_empty;
    assign mem_if.mem_rsp_data  = r_q_data[r_rd_ptr[c_QPTR_W-1:0]];
    assign mem_if.mem_rsp_tag   = r_q_tag[r_rd_ptr[c_QPTR_W-1:0]];

    a_no_queue_overflow: assert property (
        @(posedge clk) disable iff (reset) !(w_pipe_out_valid && w_q_full)
    );

`ifdef DBG_TRACE_CORE_MEM
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            $display("%0t mem_req: rw=%0b addr=0x%0h tag=0x%0h byteen=0x%0h",
                     $time, mem_if.mem_req_rw, mem_if.mem_req_addr,
                     mem_if.mem_req_tag, mem_if.mem_req_byteen);
        end
        if (w_rsp_fire) begin
            $display("%0t mem_rsp: tag=0x%0h", $time, mem_if.mem_rsp_tag);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vx_mem_responder.sv
// ============================================================================
// Module   : tb_vx_mem_responder
// Brief    : Scoreboard bench for vx_mem_responder with directed and random
//            traffic against a word-level memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vx_mem_responder;
    localparam int DW = 512;
    localparam int AW = 26;
    localparam int TW = 8;
    localparam int BW = DW / 8;
    localparam int L  = 4;
    localparam int Q  = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        int            t;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   rnd_rdy = 0;

    exp_t          exp_q[$];
    logic [DW-1:0] ram_m [int];

    vx_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) mif ();

    vx_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
        .MEM_DEPTH_LOG2(10), .LATENCY(L), .RSP_QUEUE_SIZE(Q)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .mem_if (mif.slave),
        .busy   (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name,
                         input logic [DW-1:0] act, input logic [DW-1:0] expv);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = $urandom;
        return w;
    endfunction

    // Issue one request starting just after a rising edge; returns its fire cycle.
    task automatic issue(input bit rw, input logic [AW-1:0] addr,
                         input logic [BW-1:0] be, input logic [DW-1:0] data,
                         input logic [TW-1:0] tag, output int fcyc);
        int            idx;
        bit            fired;
        logic [DW-1:0] w;
        idx   = int'(addr & 26'h3FF);
        fired = 0;
        fcyc  = -1;
        mif.mem_req_valid  = 1'b1;
        mif.mem_req_rw     = rw;
        mif.mem_req_addr   = addr;
        mif.mem_req_byteen = be;
        mif.mem_req_data   = data;
        mif.mem_req_tag    = tag;
        for (int k = 0; k < 200 && !fired; k++) begin
            @(negedge clk);
            if (mif.mem_req_ready) begin
                fired = 1;
                fcyc  = cyc;
            end
            @(posedge clk);
            #1;
        end
        mif.mem_req_valid = 1'b0;
        if (!fired) begin
            check(0, "req_accept_timeout", 0, 1);
        end else if (rw) begin
            w = ram_m.exists(idx) ? ram_m[idx] : 'x;
            for (int b = 0; b < BW; b++) if (be[b]) w[8*b +: 8] = data[8*b +: 8];
            ram_m[idx] = w;
        end else begin
            exp_q.push_back('{data: ram_m[idx], tag: tag, t: fcyc});
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    endtask

    // Monitor: compares every response and tracks the credit-visible outputs.
    initial begin
        int            last_pop;
        int            er;
        bit            seen;
        bit            stalled;
        logic [DW-1:0] held_d;
        logic [TW-1:0] held_t;
        last_pop = -1000;
        seen     = 0;
        stalled  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_pop = -1000;
                seen     = 0;
                stalled  = 0;
            end else begin
                check(busy == (exp_q.size() != 0), "busy", busy, exp_q.size() != 0);
                check(mif.mem_req_ready == (exp_q.size() < Q), "req_ready",
                      mif.mem_req_ready, exp_q.size() < Q);
                if (mif.mem_rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check(0, "unexpected_rsp", mif.mem_rsp_tag, 0);
                    end else begin
                        if (!seen) begin
                            er = exp_q[0].t + L;
                            if (last_pop + 1 > er) er = last_pop + 1;
                            check(cyc == er, "rsp_latency", cyc, er);
                            seen = 1;
                        end else if (stalled) begin
                            check(mif.mem_rsp_data == held_d && mif.mem_rsp_tag == held_t,
                                  "stall_hold", mif.mem_rsp_tag, held_t);
                        end
                        if (mif.mem_rsp_ready) begin
                            check(mif.mem_rsp_data === exp_q[0].data, "rsp_data",
                                  mif.mem_rsp_data, exp_q[0].data);
                            check(mif.mem_rsp_tag === exp_q[0].tag, "rsp_tag",
                                  mif.mem_rsp_tag, exp_q[0].tag);
                            void'(exp_q.pop_front());
                            last_pop = cyc;
                            seen     = 0;
                            stalled  = 0;
                        end else begin
                            stalled = 1;
                            held_d  = mif.mem_rsp_data;
                            held_t  = mif.mem_rsp_tag;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_rdy) mif.mem_rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int            f;
        int            r;
        int            hi;
        int            idxs [16];
        logic [DW-1:0] x;
        logic [AW-1:0] a;

        mif.mem_req_valid  = 1'b0;
        mif.mem_req_rw     = 1'b0;
        mif.mem_req_addr   = '0;
        mif.mem_req_byteen = '0;
        mif.mem_req_data   = '0;
        mif.mem_req_tag    = '0;
        mif.mem_rsp_ready  = 1'b1;

        @(negedge clk);
        check(mif.mem_req_ready == 1'b1, "reset_req_ready", mif.mem_req_ready, 1);
        check(mif.mem_rsp_valid == 1'b0, "reset_rsp_valid", mif.mem_rsp_valid, 0);
        check(busy == 1'b0, "reset_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Write then read, full byte enables.
        issue(1, 26'h10, '1, {BW{8'hA5}}, 8'd1, f);
        issue(0, 26'h10, '0, '0, 8'd7, f);
        drain();

        // Partial write over a zeroed word.
        issue(1, 26'h20, '1, '0, 8'd2, f);
        issue(1, 26'h20, 64'h1, {BW{8'hFF}}, 8'd3, f);
        issue(0, 26'h20, '0, '0, 8'd8, f);
        drain();

        // Backpressure: four reads fill the credits, fifth waits for a response.
        mif.mem_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(0, (i % 2) ? 26'h20 : 26'h10, '0, '0, 8'h30 + 8'(i), f);
        hi = 0;
        repeat (6) begin
            @(negedge clk);
            if (mif.mem_req_ready) hi++;
        end
        check(hi == 0, "bp_ready_low_cycles", hi, 0);
        @(posedge clk);
        #1;
        mif.mem_rsp_ready = 1'b1;
        r = cyc;
        issue(0, 26'h10, '0, '0, 8'h34, f);
        check(f == r + 1, "bp_fifth_accept_cycle", f, r + 1);
        drain();

        // Upper address bits alias onto the same word.
        x = rand_word();
        issue(1, 26'h400, '1, x, 8'd4, f);
        issue(0, 26'h000, '0, '0, 8'd9, f);
        drain();

        // Reset with reads in flight drops them but keeps RAM.
        x = rand_word();
        issue(1, 26'h55, '1, x, 8'd5, f);
        mif.mem_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(0, 26'h55, '0, '0, 8'h40 + 8'(i), f);
        @(posedge clk);
        #3;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check(mif.mem_rsp_valid == 1'b0, "midreset_rsp_valid", mif.mem_rsp_valid, 0);
        check(busy == 1'b0, "midreset_busy", busy, 0);
        check(mif.mem_req_ready == 1'b1, "midreset_req_ready", mif.mem_req_ready, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        mif.mem_rsp_ready = 1'b1;
        issue(0, 26'h55, '0, '0, 8'h50, f);
        drain();

        // Random traffic over a small aliased working set.
        for (int i = 0; i < 16; i++) begin
            idxs[i] = (i * 67 + 3) % 1024;
            issue(1, AW'(idxs[i]), '1, rand_word(), 8'($urandom), f);
        end
        rnd_rdy = 1;
        for (int n = 0; n < 300; n++) begin
            a = AW'({$urandom} & 32'h03FF_FC00) | AW'(idxs[$urandom_range(0, 15)]);
            if ($urandom_range(0, 3) == 0)
                issue(1, a, {$urandom, $urandom}, rand_word(), 8'($urandom), f);
            else
                issue(0, a, '0, '0, 8'($urandom), f);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        rnd_rdy = 0;
        mif.mem_rsp_ready = 1'b1;
        drain();

        // Sustained back-to-back reads with the consumer always ready.
        for (int n = 0; n < 100; n++) issue(0, AW'(idxs[n % 16]), '0, '0, 8'(n), f);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
